// File: rtl/reg_sb_pkg.sv
// Shared types and constants for the register scoreboard.
// Optional feature macro used by the scoreboard: FWD_BYPASS_EN.
package reg_sb_pkg;

   localparam int NREG     = 32;
   localparam int AW       = $clog2(NREG);
   localparam int CNT_W    = 2;
   localparam int MAX_PEND = (2 ** CNT_W) - 1;
   localparam int ZERO_REG = 0;

   typedef logic [AW-1:0]    reg_idx_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
// Counts issued-but-not-retired writes; never wraps in either direction.
// A retire with nothing pending raises a one-cycle underflow pulse.
module sb_counter
   import reg_sb_pkg::*;
#(
   parameter int CNT_W = reg_sb_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             nz,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Count update: clear wins, simultaneous inc/dec cancel, saturate at both ends.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !dec && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign nz        = (cnt != '0);
   assign underflow = dec & ~inc & ~nz;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per architectural register
// and stalls issue while a source is still pending or a destination counter
// is saturated. Register 0 is hard-wired zero and never tracked.
// Optional feature macro: FWD_BYPASS_EN (same-cycle writeback forwarding).
module reg_scoreboard
   import reg_sb_pkg::*;
#(
   parameter int NREG  = reg_sb_pkg::NREG,
   parameter int AW    = reg_sb_pkg::AW,
   parameter int CNT_W = reg_sb_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  issue_valid,
   input  logic                  issue_wr,
   input  logic [AW-1:0]         issue_rd,
   input  logic [AW-1:0]         rs1,
   input  logic [AW-1:0]         rs2,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_rd,
   output logic                  stall,
   output logic                  issue_fire,
   output logic [NREG-1:0]       busy_mask,
   output logic [AW+CNT_W-1:0]   pend_total,
`ifdef FWD_BYPASS_EN
   output logic                  rs1_fwd,
   output logic                  rs2_fwd,
`endif
   output logic                  wb_underflow
);

   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 ** CNT_W - 1);
   localparam logic [AW-1:0]    IDX_ZERO = AW'(ZERO_REG);

   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [NREG-1:0]            nz;
   logic [NREG-1:0]            uf_vec;
   logic                       src1_haz, src2_haz, dst_haz;

   // x0 is never counted.
   assign cnt[0]    = '0;
   assign nz[0]     = 1'b0;
   assign uf_vec[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      logic inc_r, dec_r;
      assign inc_r = issue_fire & issue_wr & (issue_rd == AW'(r));
      assign dec_r = wb_valid & (wb_rd == AW'(r));
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .clr       (flush),
         .inc       (inc_r),
         .dec       (dec_r),
         .cnt       (cnt[r]),
         .nz        (nz[r]),
         .underflow (uf_vec[r])
      );
   end

`ifdef FWD_BYPASS_EN
   // A single pending write that retires this cycle is forwarded, not stalled on.
   logic wb_hit1, wb_hit2;
   assign wb_hit1  = wb_valid & (wb_rd == rs1);
   assign wb_hit2  = wb_valid & (wb_rd == rs2);
   assign src1_haz = rs1_used & ((cnt[rs1] > CNT_W'(1)) | ((cnt[rs1] == CNT_W'(1)) & ~wb_hit1));
   assign src2_haz = rs2_used & ((cnt[rs2] > CNT_W'(1)) | ((cnt[rs2] == CNT_W'(1)) & ~wb_hit2));
   assign rs1_fwd  = rs1_used & (rs1 != IDX_ZERO) & wb_hit1 & (cnt[rs1] == CNT_W'(1));
   assign rs2_fwd  = rs2_used & (rs2 != IDX_ZERO) & wb_hit2 & (cnt[rs2] == CNT_W'(1));
`else
   assign src1_haz = rs1_used & nz[rs1];
   assign src2_haz = rs2_used & nz[rs2];
`endif

   assign dst_haz    = issue_wr & (cnt[issue_rd] == CNT_SAT);
   assign stall      = issue_valid & (src1_haz | src2_haz | dst_haz);
   assign issue_fire = issue_valid & ~stall & ~flush;

   // Busy view comes straight from the count flops.
   assign busy_mask = nz;

   // Total outstanding writes across all tracked registers.
   always_comb begin
      pend_total = '0;
      for (int r = 1; r < NREG; r++) begin
         pend_total = pend_total + (AW+CNT_W)'(cnt[r]);
      end
   end

   // Sticky record of any retire that found nothing pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_underflow <= 1'b0;
      end else if (|uf_vec) begin
         wb_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard with a reference model and an
// expectation queue for the registered outputs.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        reset, flush, issue_valid, issue_wr;
   logic [4:0]  issue_rd, rs1, rs2, wb_rd;
   logic        rs1_used, rs2_used, wb_valid;
   logic        stall, issue_fire;
   logic [31:0] busy_mask;
   logic [6:0]  pend_total;
   logic        wb_underflow;
`ifdef FWD_BYPASS_EN
   logic        rs1_fwd, rs2_fwd;
`endif

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_wr     (issue_wr),
      .issue_rd     (issue_rd),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_used     (rs1_used),
      .rs2_used     (rs2_used),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .stall        (stall),
      .issue_fire   (issue_fire),
      .busy_mask    (busy_mask),
      .pend_total   (pend_total),
`ifdef FWD_BYPASS_EN
      .rs1_fwd      (rs1_fwd),
      .rs2_fwd      (rs2_fwd),
`endif
      .wb_underflow (wb_underflow)
   );

   typedef struct {
      logic [31:0] mask;
      logic [6:0]  total;
      logic        uf;
   } exp_t;

   exp_t exp_q[$];
   exp_t got;
   int   checks = 0;
   int   errors = 0;
   int   mcnt[32];
   bit   muf;

   function automatic bit mbusy(int r, bit wv, int wr);
      if (r == 0) return 1'b0;
`ifdef FWD_BYPASS_EN
      return (mcnt[r] > 1) || (mcnt[r] == 1 && !(wv && wr == r));
`else
      return mcnt[r] != 0;
`endif
   endfunction

   function automatic bit exp_stall();
      bit s1, s2, d;
      s1 = rs1_used && mbusy(int'(rs1), wb_valid, int'(wb_rd));
      s2 = rs2_used && mbusy(int'(rs2), wb_valid, int'(wb_rd));
      d  = issue_wr && issue_rd != 0 && mcnt[issue_rd] == 3;
      return issue_valid && (s1 || s2 || d);
   endfunction

   function automatic bit exp_fire();
      return issue_valid && !exp_stall() && !flush;
   endfunction

   task automatic drive(input bit iv, input bit wr, input int rd,
                        input int r1, input bit u1, input int r2, input bit u2,
                        input bit wv, input int wrd, input bit fl);
      issue_valid = iv; issue_wr = wr; issue_rd = 5'(rd);
      rs1 = 5'(r1); rs1_used = u1; rs2 = 5'(r2); rs2_used = u2;
      wb_valid = wv; wb_rd = 5'(wrd); flush = fl;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance the model by one clock using the currently driven inputs,
   // queue the expected registered outputs, then step past the edge.
   task automatic cyc();
      exp_t e;
      bit   fire, inc, wbh;
      fire = exp_fire();
      for (int r = 1; r < 32; r++) begin
         inc = fire && issue_wr && issue_rd == r;
         wbh = wb_valid && wb_rd == r;
         if (wbh && !inc && mcnt[r] == 0) muf = 1'b1;
         if (flush) mcnt[r] = 0;
         else if (inc && !wbh) mcnt[r] = mcnt[r] + 1;
         else if (wbh && !inc && mcnt[r] != 0) mcnt[r] = mcnt[r] - 1;
      end
      e.mask = '0; e.total = '0; e.uf = muf;
      for (int r = 1; r < 32; r++) begin
         e.mask[r] = (mcnt[r] != 0);
         e.total   = e.total + 7'(mcnt[r]);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_mask, pend_total, wb_underflow, stall, issue_fire} !== '0) begin
         errors++;
         $display("FAIL reset_state: got mask=%h total=%0d uf=%b stall=%b fire=%b, want all 0",
                  busy_mask, pend_total, wb_underflow, stall, issue_fire);
      end
      reset = 1'b0;
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      muf = 1'b0;
   endtask

   task automatic test_raw();
      // cycle 0: write x5; 1: read x5; 2: read x5 with wb x5; 3: read x5
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
         else        drive(1, 0, 0, 5, 1, 0, 0, (c == 2), 5, 0);
         #1;
         checks++;
         if (stall !== exp_stall() || issue_fire !== exp_fire()) begin
            errors++;
            $display("FAIL raw_stall c%0d: got stall=%b fire=%b, want stall=%b fire=%b",
                     c, stall, issue_fire, exp_stall(), exp_fire());
         end
`ifdef FWD_BYPASS_EN
         if (c == 2) begin
            checks++;
            if (rs1_fwd !== 1'b1 || stall !== 1'b0) begin
               errors++;
               $display("FAIL raw_fwd: got rs1_fwd=%b stall=%b, want 1 0", rs1_fwd, stall);
            end
         end
`else
         checks++;
         if (stall !== (c == 1 || c == 2)) begin
            errors++;
            $display("FAIL raw_stall_fixed c%0d: got %b, want %b", c, stall, (c == 1 || c == 2));
         end
`endif
         cyc();
         got = exp_q.pop_front();
         checks++;
         if ({busy_mask, pend_total, wb_underflow} !== {got.mask, got.total, got.uf}) begin
            errors++;
            $display("FAIL raw_state c%0d: got %h/%0d/%b, want %h/%0d/%b", c,
                     busy_mask, pend_total, wb_underflow, got.mask, got.total, got.uf);
         end
      end
      @(negedge clk); idle();
   endtask

   task automatic test_saturate();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
         #1;
         checks++;
         if (stall !== (c == 3) || stall !== exp_stall()) begin
            errors++;
            $display("FAIL sat_stall c%0d: got %b, want %b", c, stall, (c == 3));
         end
         cyc();
         got = exp_q.pop_front();
         checks++;
         if ({busy_mask, pend_total} !== {got.mask, got.total}) begin
            errors++;
            $display("FAIL sat_state c%0d: got %h/%0d, want %h/%0d", c,
                     busy_mask, pend_total, got.mask, got.total);
         end
      end
      checks++;
      if (pend_total !== 7'd3) begin
         errors++;
         $display("FAIL sat_total: got %0d, want 3", pend_total);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
         cyc();
         got = exp_q.pop_front();
      end
      checks++;
      if (pend_total !== 7'd0 || busy_mask[7] !== 1'b0) begin
         errors++;
         $display("FAIL sat_drain: got total=%0d busy7=%b, want 0 0", pend_total, busy_mask[7]);
      end
      @(negedge clk); idle();
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      got = exp_q.pop_front();
      @(negedge clk);
      drive(1, 1, 9, 0, 0, 0, 0, 1, 9, 0);
      #1;
      checks++;
      if (issue_fire !== 1'b1) begin
         errors++;
         $display("FAIL same_fire: got %b, want 1", issue_fire);
      end
      cyc();
      got = exp_q.pop_front();
      checks++;
      if (busy_mask[9] !== 1'b1 || pend_total !== 7'd1 || pend_total !== got.total) begin
         errors++;
         $display("FAIL same_count: got busy9=%b total=%0d, want 1 1", busy_mask[9], pend_total);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      cyc();
      got = exp_q.pop_front();
      @(negedge clk); idle();
   endtask

   task automatic test_flush();
      @(negedge clk); drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); cyc(); got = exp_q.pop_front();
      @(negedge clk); drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); cyc(); got = exp_q.pop_front();
      checks++;
      if (pend_total !== 7'd2) begin
         errors++;
         $display("FAIL flush_pre: got total=%0d, want 2", pend_total);
      end
      @(negedge clk);
      drive(1, 1, 6, 0, 0, 0, 0, 1, 3, 1);
      #1;
      checks++;
      if (issue_fire !== 1'b0) begin
         errors++;
         $display("FAIL flush_fire: got %b, want 0", issue_fire);
      end
      cyc();
      got = exp_q.pop_front();
      checks++;
      if (busy_mask !== 32'h0 || pend_total !== 7'd0 || got.total !== 7'd0) begin
         errors++;
         $display("FAIL flush_clear: got mask=%h total=%0d, want 0 0", busy_mask, pend_total);
      end
      @(negedge clk); idle();
   endtask

   task automatic test_x0();
      @(negedge clk);
      drive(1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b0 || issue_fire !== 1'b1) begin
         errors++;
         $display("FAIL x0_issue: got stall=%b fire=%b, want 0 1", stall, issue_fire);
      end
      cyc();
      got = exp_q.pop_front();
      checks++;
      if ({busy_mask, pend_total, wb_underflow} !== {got.mask, got.total, got.uf} || wb_underflow !== 1'b0) begin
         errors++;
         $display("FAIL x0_state: got %h/%0d/%b, want %h/%0d/%b",
                  busy_mask, pend_total, wb_underflow, got.mask, got.total, got.uf);
      end
      @(negedge clk); idle();
   endtask

   task automatic test_underflow();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
      cyc();
      got = exp_q.pop_front();
      checks++;
      if (wb_underflow !== 1'b1 || got.uf !== 1'b1 || pend_total !== 7'd0) begin
         errors++;
         $display("FAIL uf_set: got uf=%b total=%0d, want 1 0", wb_underflow, pend_total);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); idle(); cyc(); got = exp_q.pop_front();
      end
      checks++;
      if (wb_underflow !== 1'b1) begin
         errors++;
         $display("FAIL uf_sticky: got %b, want 1", wb_underflow);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk); drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); cyc(); got = exp_q.pop_front();
      @(negedge clk); drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); cyc(); got = exp_q.pop_front();
      @(negedge clk);
      idle();
      #1 reset = 1'b1;
      #1;
      checks++;
      if (busy_mask !== 32'h0 || pend_total !== 7'd0 || wb_underflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got mask=%h total=%0d uf=%b, want 0 0 0",
                  busy_mask, pend_total, wb_underflow);
      end
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      muf = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         drive($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(7, 0),
               $urandom_range(7, 0), $urandom_range(1, 0) == 1,
               $urandom_range(7, 0), $urandom_range(1, 0) == 1,
               $urandom_range(2, 0) != 0, $urandom_range(7, 0), $urandom_range(15, 0) == 0);
         #1;
         checks++;
         if (stall !== exp_stall() || issue_fire !== exp_fire()) begin
            errors++;
            $display("FAIL b2b_stall c%0d: got stall=%b fire=%b, want stall=%b fire=%b",
                     c, stall, issue_fire, exp_stall(), exp_fire());
         end
         cyc();
         got = exp_q.pop_front();
         checks++;
         if ({busy_mask, pend_total, wb_underflow} !== {got.mask, got.total, got.uf}) begin
            errors++;
            $display("FAIL b2b_state c%0d: got %h/%0d/%b, want %h/%0d/%b", c,
                     busy_mask, pend_total, wb_underflow, got.mask, got.total, got.uf);
         end
      end
      @(negedge clk); idle();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_saturate();
      test_same_cycle();
      test_flush();
      test_x0();
      test_underflow();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
